// File: rtl/ram_rw_pkg.sv
// Shared types and the data-pattern generator for the RAM write/read-back tester.
package ram_rw_pkg;

  // Internal width of pattern arithmetic; callers truncate to their data width.
  localparam int PAT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_CNT  = 2'd0,
    MODE_INV  = 2'd1,
    MODE_SEED = 2'd2,
    MODE_WALK = 2'd3
  } mode_t;

  // Expected word for a given address; result is truncated to data_w by the caller.
  function automatic logic [PAT_W-1:0] pat(
    input logic [PAT_W-1:0] addr,
    input mode_t            mode,
    input logic [PAT_W-1:0] seed,
    input int unsigned      data_w
  );
    logic [PAT_W-1:0] r;
    case (mode)
      MODE_CNT:  r = addr;
      MODE_INV:  r = ~addr;
      MODE_SEED: r = seed + addr;
      default:   r = PAT_W'(1) << (addr % data_w);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ram_rw_pipe.sv
// Expected-value pipeline: carries {valid, addr, expected} alongside the RAM read latency.
module ram_rw_pipe #(
  parameter int AW    = 5,
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_exp,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_exp,
  output logic          any_valid
);

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DW-1:0] exp_q, exp_d;

  // Shift each stage one step toward the output; new entry enters stage 0.
  always_comb begin
    valid_d    = valid_q;
    addr_d     = addr_q;
    exp_d      = exp_q;
    valid_d[0] = in_valid;
    addr_d[0]  = in_addr;
    exp_d[0]   = in_exp;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      addr_d[i]  = addr_q[i-1];
      exp_d[i]   = exp_q[i-1];
    end
  end

  // Only the valid bits need clearing; payload is ignored while invalid.
  always_ff @(posedge clk) begin
    if (srst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    addr_q <= addr_d;
    exp_q  <= exp_d;
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];
  assign out_exp   = exp_q[DEPTH-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/ram_rw_check.sv
// RAM write/read-back self-test engine: full write pass, full read pass, compare and report.
// DATA_W and ADDR_W must not exceed 32 (pattern arithmetic width).
module ram_rw_check #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              loop,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  import ram_rw_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_err_q, first_err_d;

  logic                pipe_out_valid;
  logic [ADDR_W-1:0]   pipe_out_addr;
  logic [DATA_W-1:0]   pipe_out_exp;
  logic                pipe_any_valid;
  logic                rd_issue;
  logic [DATA_W-1:0]   rd_exp;

  // A read is in flight in any cycle the RAM is enabled without write enable.
  assign rd_issue = ram_en_q & ~ram_we_q;
  assign rd_exp   = DATA_W'(pat(PAT_W'(ram_addr_q), mode_q, PAT_W'(seed_q), DATA_W));

  ram_rw_pipe #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (RD_LAT)
  ) u_pipe (
    .clk       (sys_clk),
    .srst      (sys_rst),
    .in_valid  (rd_issue),
    .in_addr   (ram_addr_q),
    .in_exp    (rd_exp),
    .out_valid (pipe_out_valid),
    .out_addr  (pipe_out_addr),
    .out_exp   (pipe_out_exp),
    .any_valid (pipe_any_valid)
  );

  // Next-state and next-output logic for the sequencer and the compare/accumulate path.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;

    // Compare the word leaving the latency pipeline; err_cnt==0 marks the first miss.
    if (pipe_out_valid && (ram_rdata != pipe_out_exp)) begin
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
      if (err_cnt_q == 16'd0) begin
        first_err_d = pipe_out_addr;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WRITE;
          mode_d      = mode_t'(mode);
          seed_d      = seed;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_cnt_d   = 16'd0;
          first_err_d = '0;
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = '0;
        end
      end
      WRITE: begin
        if (ram_addr_q == ADDR_LAST) begin
          state_d    = READ;
          ram_we_d   = 1'b0;
          ram_addr_d = '0;
        end else begin
          ram_addr_d = ram_addr_q + ADDR_W'(1);
        end
      end
      READ: begin
        if (ram_addr_q == ADDR_LAST) begin
          state_d    = DRAIN;
          ram_en_d   = 1'b0;
          ram_addr_d = '0;
        end else begin
          ram_addr_d = ram_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // Leave only once every outstanding read has been compared.
        if (!pipe_any_valid) begin
          if (loop) begin
            state_d    = WRITE;
            ram_en_d   = 1'b1;
            ram_we_d   = 1'b1;
            ram_addr_d = '0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (err_cnt_q == 16'd0);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ram_wdata_d = ram_we_d ? DATA_W'(pat(PAT_W'(ram_addr_d), mode_d, PAT_W'(seed_d), DATA_W))
                           : '0;
  end

  // State and registered outputs; reset aborts any run in progress without a done pulse.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_CNT;
      seed_q      <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= 16'd0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign ram_en         = ram_en_q;
  assign ram_we         = ram_we_q;
  assign ram_addr       = ram_addr_q;
  assign ram_wdata      = ram_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_ram_rw_check.sv
// Bench for ram_rw_check: two instances (defaults, and 4/16/RD_LAT=3) against behavioural RAMs.
module tb_ram_rw_check;

  localparam int NA  = 32;
  localparam int NB  = 16;
  localparam int PLA = 2 * NA + 1 + 1;   // cycles per pass, defaults
  localparam int PLB = 2 * NB + 3 + 1;   // cycles per pass, instance B

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sys_rst;

  logic        start_a, loop_a;
  logic [1:0]  mode_a;
  logic [7:0]  seed_a;
  logic        en_a, we_a;
  logic [4:0]  addr_a;
  logic [7:0]  wdata_a, rdata_a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] err_a;
  logic [4:0]  first_a;

  logic        start_b, loop_b;
  logic [1:0]  mode_b;
  logic [15:0] seed_b;
  logic        en_b, we_b;
  logic [3:0]  addr_b;
  logic [15:0] wdata_b, rdata_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] err_b;
  logic [3:0]  first_b;

  ram_rw_check u_dut_a (
    .sys_clk(clk), .sys_rst(sys_rst), .start(start_a), .mode(mode_a), .seed(seed_a),
    .loop(loop_a), .ram_en(en_a), .ram_we(we_a), .ram_addr(addr_a), .ram_wdata(wdata_a),
    .ram_rdata(rdata_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_err_addr(first_a)
  );

  ram_rw_check #(.ADDR_W(4), .DATA_W(16), .RD_LAT(3)) u_dut_b (
    .sys_clk(clk), .sys_rst(sys_rst), .start(start_b), .mode(mode_b), .seed(seed_b),
    .loop(loop_b), .ram_en(en_b), .ram_we(we_b), .ram_addr(addr_b), .ram_wdata(wdata_b),
    .ram_rdata(rdata_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_err_addr(first_b)
  );

  // Behavioural RAM A: 1-cycle read, per-address bit flips and stuck-at-0 bits on read.
  logic [7:0] mem_a [NA];
  logic [7:0] flip_a [NA];
  logic [7:0] stuck_a [NA];
  logic       scr_a = 1'b0;
  always @(posedge clk) begin
    if (scr_a) begin
      for (int i = 0; i < NA; i++) mem_a[i] <= 8'($urandom);
    end else if (en_a) begin
      if (we_a) mem_a[addr_a] <= wdata_a;
      else      rdata_a <= (mem_a[addr_a] ^ flip_a[addr_a]) & ~stuck_a[addr_a];
    end
  end

  // Behavioural RAM B: 3-cycle read latency, per-address bit flips on read.
  logic [15:0] mem_b [NB];
  logic [15:0] flip_b [NB];
  logic [15:0] rd1_b, rd2_b, rd3_b;
  logic        scr_b = 1'b0;
  always @(posedge clk) begin
    if (scr_b) begin
      for (int i = 0; i < NB; i++) mem_b[i] <= 16'($urandom);
    end else if (en_b && we_b) begin
      mem_b[addr_b] <= wdata_b;
    end
    rd1_b <= mem_b[addr_b] ^ flip_b[addr_b];
    rd2_b <= rd1_b;
    rd3_b <= rd2_b;
  end
  assign rdata_b = rd3_b;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference pattern straight from the mode definitions, using plain modular arithmetic.
  function automatic logic [31:0] ref_pat(input int a, input int md, input int sd, input int dw);
    longint unsigned m;
    longint unsigned v;
    m = 64'd1 << dw;
    case (md)
      0:       v = longint'(a) % m;
      1:       v = (m - 1) - (longint'(a) % m);
      2:       v = longint'(sd + a) % m;
      default: v = 64'd1 << (a % dw);
    endcase
    return v[31:0];
  endfunction

  task automatic scramble_a();
    @(negedge clk); scr_a = 1'b1;
    @(negedge clk); scr_a = 1'b0;
  endtask

  task automatic scramble_b();
    @(negedge clk); scr_b = 1'b1;
    @(negedge clk); scr_b = 1'b0;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < NA; i++) begin flip_a[i] = 8'h00; stuck_a[i] = 8'h00; end
    for (int i = 0; i < NB; i++) flip_b[i] = 16'h0000;
  endtask

  // Called in cycle T+1 of a run; returns in the first idle cycle after done.
  task automatic wait_a(input int drop_at, input bit spam, input bit chain,
                        output int lat, output int ndone);
    lat   = -1;
    ndone = 0;
    for (int n = 1; n <= 5 * PLA; n++) begin
      if (lat >= 0 && !busy_a) begin
        check_val("a_busy_drop_cycle", n, lat + 2);
        start_a = chain;
        return;
      end
      if (done_a) begin
        ndone++;
        if (lat < 0) lat = n - 1;
      end
      if (n == drop_at) loop_a = 1'b0;
      start_a = (chain && done_a) || (spam && busy_a && ($urandom_range(0, 3) == 0));
      @(negedge clk);
    end
    start_a = 1'b0;
    check_val("a_timeout_busy", busy_a, 0);
  endtask

  task automatic launch_a(input int md, input int sd, input bit lp);
    @(negedge clk);
    mode_a  = md[1:0];
    seed_a  = sd[7:0];
    loop_a  = lp;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_val("a_start_busy", busy_a, 1);
    check_val("a_start_we", we_a, 1);
    check_val("a_start_addr", addr_a, 0);
  endtask

  task automatic test_a(input int md, input int sd, input int drop_at, input bit spam);
    int lat, nd, per, first, passes, exp_err, bad_mem;
    bit found;
    logic [31:0] e, g;
    scramble_a();
    launch_a(md, sd, drop_at > 0);
    wait_a(drop_at, spam, 1'b0, lat, nd);
    per = 0; first = 0; found = 1'b0; bad_mem = 0;
    for (int a = 0; a < NA; a++) begin
      e = ref_pat(a, md, sd, 8);
      g = {24'h0, (e[7:0] ^ flip_a[a]) & ~stuck_a[a]};
      if (g[7:0] != e[7:0]) begin
        per++;
        if (!found) first = a;
        found = 1'b1;
      end
      if (mem_a[a] !== e[7:0]) bad_mem++;
    end
    passes  = (drop_at > 0) ? (drop_at + PLA - 1) / PLA : 1;
    exp_err = (per * passes > 65535) ? 65535 : per * passes;
    check_val("a_err_cnt", err_a, exp_err);
    check_val("a_first_err", first_a, first);
    check_val("a_pass", pass_a, (exp_err == 0) ? 1 : 0);
    check_val("a_latency", lat, passes * PLA);
    check_val("a_done_pulses", nd, 1);
    check_val("a_mem_mismatches", bad_mem, 0);
    $display("run A mode=%0d seed=%0h passes=%0d err=%0d first=%0d pass=%0d lat=%0d",
             md, sd, passes, err_a, first_a, pass_a, lat);
  endtask

  task automatic test_b(input int md, input int sd);
    int lat, nd, per, first, bad_mem, stop_n;
    bit found;
    logic [31:0] e;
    scramble_b();
    @(negedge clk);
    mode_b  = md[1:0];
    seed_b  = sd[15:0];
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check_val("b_start_busy", busy_b, 1);
    lat = -1; nd = 0; stop_n = -1;
    for (int n = 1; n <= 3 * PLB; n++) begin
      if (lat >= 0 && !busy_b) begin stop_n = n; break; end
      if (done_b) begin nd++; if (lat < 0) lat = n - 1; end
      @(negedge clk);
    end
    check_val("b_busy_drop_cycle", stop_n, lat + 2);
    per = 0; first = 0; found = 1'b0; bad_mem = 0;
    for (int a = 0; a < NB; a++) begin
      e = ref_pat(a, md, sd, 16);
      if (flip_b[a] != 16'h0) begin
        per++;
        if (!found) first = a;
        found = 1'b1;
      end
      if (mem_b[a] !== e[15:0]) bad_mem++;
    end
    check_val("b_err_cnt", err_b, per);
    check_val("b_first_err", first_b, first);
    check_val("b_pass", pass_b, (per == 0) ? 1 : 0);
    check_val("b_latency", lat, PLB);
    check_val("b_done_pulses", nd, 1);
    check_val("b_mem_mismatches", bad_mem, 0);
    $display("run B mode=%0d seed=%0h err=%0d first=%0d pass=%0d lat=%0d",
             md, sd, err_b, first_b, pass_b, lat);
  endtask

  initial begin
    int lat, nd;
    sys_rst = 1'b1;
    start_a = 1'b0; loop_a = 1'b0; mode_a = 2'd0; seed_a = 8'h00;
    start_b = 1'b0; loop_b = 1'b0; mode_b = 2'd0; seed_b = 16'h0000;
    clear_faults();
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy_a, 0);
    check_val("rst_done", done_a, 0);
    check_val("rst_pass", pass_a, 0);
    check_val("rst_err", err_a, 0);
    check_val("rst_ram", {en_a, we_a, addr_a, wdata_a}, 0);
    check_val("rst_b_busy", busy_b, 0);
    sys_rst = 1'b0;

    // Counting pattern, then seeded pattern with wraparound.
    test_a(0, 0, 0, 1'b0);
    test_a(2, 'hF0, 0, 1'b0);
    check_val("a_mem31_seed", mem_a[31], 8'h0F);

    // Inverted pattern with bit 0 corrupted at two addresses.
    flip_a[5] = 8'h01; flip_a[20] = 8'h01;
    test_a(1, 0, 0, 1'b0);
    check_val("a_two_faults_err", err_a, 2);
    check_val("a_two_faults_first", first_a, 5);
    clear_faults();

    // Looping with a stuck bit at address 7; loop released during the third pass.
    stuck_a[7] = 8'h01;
    test_a(0, 0, 2 * PLA + 18, 1'b0);
    check_val("a_loop_err", err_a, 3);
    check_val("a_loop_first", first_a, 7);
    clear_faults();

    // Randomised modes, seeds and fault sets.
    for (int r = 0; r < 5; r++) begin
      int nf;
      nf = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) flip_a[$urandom_range(0, NA - 1)] = 8'($urandom_range(1, 255));
      test_a($urandom_range(0, 3), $urandom_range(0, 255), 0, 1'b0);
      clear_faults();
    end

    // Reset in the middle of the read pass, after one error has been counted.
    flip_a[2] = 8'h01;
    scramble_a();
    launch_a(0, 0, 1'b0);
    repeat (44) @(negedge clk);
    check_val("mid_busy", busy_a, 1);
    check_val("mid_err", err_a, 1);
    sys_rst = 1'b1;
    @(negedge clk);
    check_val("abort_busy", busy_a, 0);
    check_val("abort_done", done_a, 0);
    check_val("abort_pass", pass_a, 0);
    check_val("abort_err", err_a, 0);
    check_val("abort_first", first_a, 0);
    check_val("abort_ram", {en_a, we_a, addr_a, wdata_a}, 0);
    sys_rst = 1'b0;
    clear_faults();
    test_a(0, 0, 0, 1'b1);

    // start during done is ignored; start in the following cycle is accepted.
    launch_a(1, 0, 1'b0);
    wait_a(0, 1'b0, 1'b1, lat, nd);
    check_val("chain_lat", lat, PLA);
    check_val("chain_done_pulses", nd, 1);
    @(negedge clk);
    start_a = 1'b0;
    check_val("chain_busy", busy_a, 1);
    check_val("chain_we", we_a, 1);
    check_val("chain_addr", addr_a, 0);
    wait_a(0, 1'b0, 1'b0, lat, nd);
    check_val("chain2_lat", lat, PLA);
    check_val("chain2_pass", pass_a, 1);
    $display("run A chained back-to-back lat=%0d pass=%0d", lat, pass_a);

    // Instance B: walking ones, then a random mode with one corrupted word.
    test_b(3, 0);
    check_val("b_mem9_walk", mem_b[9], 16'h0200);
    flip_b[$urandom_range(0, NB - 1)] = 16'($urandom_range(1, 65535));
    test_b($urandom_range(0, 3), $urandom_range(0, 65535));
    clear_faults();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_rw_check.md
# ram_rw_check

Parametrised RAM write/read-back self-test engine; the successor to the fixed 32x8 write/read sequencer. It drives a single-port RAM (IP block RAM or equivalent) through a full write pass and a full read pass over all 2^ADDR_W locations using a selectable data pattern. It compares every read word against the expected value, accounting for the RAM's read latency, and reports pass/fail, error count and first failing address. It sits between a control source (buttons, VIO or a test sequencer) and the RAM port.

## Interface
- ADDR_W, 5: RAM address width; depth = 2^ADDR_W.
- DATA_W, 8: RAM data width.
- RD_LAT, 1: cycles from a read address (en=1, we=0) to valid ram_rdata; range 1..4.
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request; ignored while busy.
- mode  in  2  pattern select, sampled on accepted start.
- seed  in  DATA_W  pattern offset for mode 2, sampled on accepted start.
- loop  in  1  when 1 at end of the read pass, restart the write pass instead of finishing.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  1 if the last completed test had zero errors; held until the next start.
- err_cnt  out  16  mismatches since the last start; saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of the first mismatch since start; 0 if none.

## Operation
- Reset value of all outputs is 0; the FSM resets to IDLE.
- Pattern p(a):
  - mode 0: a, zero-extended or truncated to DATA_W.
  - mode 1: bitwise inverse of mode 0.
  - mode 2: seed + a, mod 2^DATA_W.
  - mode 3: 1 << (a mod DATA_W).
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE -> WRITE on start. On that transition: err_cnt=0, first_err_addr=0, pass=0, mode and seed latched.
- WRITE: ram_en=1, ram_we=1, ram_addr counts 0..2^ADDR_W-1, ram_wdata=p(ram_addr). After the last address -> READ with ram_addr=0.
- READ: ram_en=1, ram_we=0, ram_addr counts 0..2^ADDR_W-1. Each issued read pushes {addr, p(addr)} into an RD_LAT-deep valid pipeline. After the last address -> DRAIN.
- DRAIN: ram_en=0. Lasts RD_LAT cycles until the pipeline is empty, then:
  - -> WRITE if loop=1 (err_cnt and first_err_addr keep accumulating);
  - -> DONE otherwise.
- DONE: one cycle; done=1, pass=(err_cnt==0); -> IDLE.
- Compare: when a pipeline entry emerges valid, ram_rdata is checked against its expected value.
  - On mismatch, err_cnt increments (saturating).
  - If this is the first mismatch since start, first_err_addr is set to the entry's address.
- busy=1 in every state except IDLE. start while busy has no effect.
- Address counter wraps naturally at 2^ADDR_W-1.
- Reset asserted mid-test aborts immediately: RAM outputs go to 0, no done pulse, pass=0.

## Timing
- All outputs are registered.
- start sampled high at edge T: from T+1 busy=1, ram_we=1, ram_addr=0.
- Write pass occupies 2^ADDR_W cycles. The read pass follows with no gap.
- The read of address k is issued in cycle R+k. Its compare happens in cycle R+k+RD_LAT.
- A mismatch updates err_cnt at the edge ending its compare cycle.
- done asserts exactly 2*2^ADDR_W + RD_LAT + 1 cycles after T+1, i.e. 66 cycles for the defaults. busy drops in the cycle after done.
- start asserted in the same cycle as done is ignored. start in the cycle after done is accepted.

## Structure
- Package ram_rw_pkg holds:
  - state enum;
  - mode encodings MODE_CNT, MODE_INV, MODE_SEED, MODE_WALK;
  - pattern function pat(addr, mode, seed).
- One sub-module, ram_rw_pipe: parametrised RD_LAT-deep shift register carrying {valid, addr, expected}, with synchronous active-high reset clearing the valid bits.

## Test plan
- Defaults, behavioural RAM with RD_LAT=1, mode 0, start pulse -> addresses 0..31 written with 0..31; done after 66 cycles; pass=1; err_cnt=0.
- mode 2, seed=8'hF0 -> address 31 written with 8'h0F; pass=1.
- RAM model corrupts bit 0 at addresses 5 and 20 (mode 1) -> err_cnt=2, first_err_addr=5, pass=0.
- RD_LAT=3, ADDR_W=4, DATA_W=16, mode 3 -> address 9 written with 16'h0200; done 16+16+3+1=36 cycles after busy rises; pass=1.
- loop=1 with one stuck-at fault at address 7, loop dropped during the third pass -> err_cnt=3, single done pulse, first_err_addr=7.
- sys_rst asserted during READ, then start pulses applied during busy after restart -> all outputs 0 the cycle after reset; extra starts ignored; a new clean run gives pass=1.
